// File: rtl/instr_trace_pkg.sv
// Shared definitions for the retire tracer: MIPS opcode/funct values,
// class codes, the default-width trace entry layout and the class decoder.
package instr_trace_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;

  localparam logic [3:0] CLS_ADD   = 4'd0;
  localparam logic [3:0] CLS_SUB   = 4'd1;
  localparam logic [3:0] CLS_AND   = 4'd2;
  localparam logic [3:0] CLS_OR    = 4'd3;
  localparam logic [3:0] CLS_LW    = 4'd4;
  localparam logic [3:0] CLS_SW    = 4'd5;
  localparam logic [3:0] CLS_BEQ   = 4'd6;
  localparam logic [3:0] CLS_J     = 4'd7;
  localparam logic [3:0] CLS_OTHER = 4'd8;

  localparam int unsigned NUM_CLASS = 9;

  // Entry layout at default widths (TS_W=16, DATA_W=32); the top level
  // keeps the same field order sized by its own parameters.
  typedef struct packed {
    logic [15:0] stamp;
    logic [3:0]  cls;
    logic [31:0] pc;
    logic [31:0] wd;
  } trace_entry_t;

  function automatic logic [3:0] decode_class(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = CLS_OTHER;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  c = CLS_ADD;
          FN_SUB:  c = CLS_SUB;
          FN_AND:  c = CLS_AND;
          FN_OR:   c = CLS_OR;
          default: c = CLS_OTHER;
        endcase
      end
      OP_LW:   c = CLS_LW;
      OP_SW:   c = CLS_SW;
      OP_BEQ:  c = CLS_BEQ;
      OP_J:    c = CLS_J;
      default: c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: head entry is presented on dout while not empty (zero
// when empty). When full, a push is only accepted alongside a pop;
// otherwise it is dropped and flagged on drop for one cycle.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign fill    = count;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign dout    = empty ? '0 : mem[rptr];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since empty masks dout.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_retire_tracer.sv
// Retire trace unit: decodes each retired instruction into a class, keeps
// saturating per-class counters, and queues timestamped entries in a
// show-ahead FIFO with overflow/drop accounting.
// Optional: define TRACE_STALL_WATCHDOG_EN to build the idle watchdog (hang).
module instr_retire_tracer
  import instr_trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid,
  input  logic [DATA_W-1:0]        ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [DATA_W-1:0]        ret_wd,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_wd,
  output logic [3:0]               rd_class,
  output logic [TS_W-1:0]          rd_stamp,
  input  logic [3:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_value,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     hang
);

  typedef struct packed {
    logic [TS_W-1:0]   stamp;
    logic [3:0]        cls;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] wd;
  } entry_t;

  logic [3:0]       ret_cls;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] cnt [NUM_CLASS];
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             unused_fifo_full;
  logic             unused_instr_bits;

  assign ret_cls           = decode_class(ret_instr[31:26], ret_instr[5:0]);
  assign unused_instr_bits = ^ret_instr[25:6];

  // Assemble the entry stamped with this cycle's timestamp.
  always_comb begin
    wr_entry       = '0;
    wr_entry.stamp = ts;
    wr_entry.cls   = ret_cls;
    wr_entry.pc    = ret_pc;
    wr_entry.wd    = ret_wd;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_valid),
    .pop   (rd_en),
    .din   (wr_entry),
    .dout  (rd_entry),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .fill  (fill),
    .drop  (fifo_drop)
  );

  assign rd_valid = !fifo_empty;
  assign rd_pc    = rd_entry.pc;
  assign rd_wd    = rd_entry.wd;
  assign rd_class = rd_entry.cls;
  assign rd_stamp = rd_entry.stamp;

  // Free-running cycle timestamp, wraps modulo 2^TS_W.
  always_ff @(posedge clk) begin
    if (!rst) ts <= '0;
    else      ts <= ts + TS_W'(1);
  end

  // Saturating per-class retire counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '{default: '0};
    end else if (ret_valid && (cnt[ret_cls] != '1)) begin
      cnt[ret_cls] <= cnt[ret_cls] + CNT_W'(1);
    end
  end

  // Combinational counter read; codes beyond OTHER read as zero.
  always_comb begin
    cnt_value = '0;
    if (cnt_sel <= CLS_OTHER) cnt_value = cnt[cnt_sel];
  end

  // Sticky overflow flag and saturating drop count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef TRACE_STALL_WATCHDOG_EN
  localparam int unsigned IDLE_W = $clog2(STALL_LIMIT + 1);

  logic [IDLE_W-1:0] idle;

  // Idle counter saturates at STALL_LIMIT; hang rises on the edge the
  // count reaches the limit and holds until the next retire.
  always_ff @(posedge clk) begin
    if (!rst || ret_valid) begin
      idle <= '0;
      hang <= 1'b0;
    end else begin
      if (idle != IDLE_W'(STALL_LIMIT))     idle <= idle + IDLE_W'(1);
      if (idle == IDLE_W'(STALL_LIMIT - 1)) hang <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_stall_limit = STALL_LIMIT;
  assign hang = 1'b0;
`endif

endmodule
